core_mc_ctrl: RTL and testbench

// - Multi-cycle sequencer for core_s: steps one instruction at a time through FETCH->DECODE->EXEC->MEM->WB.
// - Drives IFU/LSU request handshakes, the IR load strobe and the PC/regfile write enables; consumes decoder flags.
// - Halts on ebreak or bus error; keeps cycle and retired-instruction counters for the simulation harness.

---
 rtl/core_pkg.sv | 28 ++
 rtl/perf_counter.sv | 24 ++
 rtl/core_mc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_core_mc_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and state encoding for the core_s multi-cycle sequencer.
// Contents: STATE_W, ctrl_state_e, and ST_* constants used by the FSM.
package core_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        IWAIT  = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        MEM    = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } ctrl_state_e;

    // Plain vector constants so the state register stays a bare logic vector.
    localparam logic [STATE_W-1:0] ST_IDLE   = IDLE;
    localparam logic [STATE_W-1:0] ST_FETCH  = FETCH;
    localparam logic [STATE_W-1:0] ST_IWAIT  = IWAIT;
    localparam logic [STATE_W-1:0] ST_DECODE = DECODE;
    localparam logic [STATE_W-1:0] ST_EXEC   = EXEC;
    localparam logic [STATE_W-1:0] ST_MEM    = MEM;
    localparam logic [STATE_W-1:0] ST_WB     = WB;
    localparam logic [STATE_W-1:0] ST_HALT   = HALT;

endpackage

// File: rtl/perf_counter.sv
// Free-running wrapping counter with enable and synchronous clear.
// Ports: clk, rst_b (async active-low), en (count), clear (sync zero), count.
module perf_counter #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // Wraps modulo 2^CNT_W; clear has priority over en.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/core_mc_ctrl.sv
// Multi-cycle sequencer for core_s: FETCH->IWAIT->DECODE->EXEC->(MEM)->WB per
// instruction, halting on ebreak or bus error.
// Ports: clk/rst_b; IFU handshake (ifu_req/ready/rvalid/err) and ir_load;
// decoder flags dec_*, bxx_taken; LSU handshake (lsu_req/ready/rvalid/err);
// WB strobes rf_write, pc_update, pc_sel_target; halt, halt_err; debug state;
// cycle_cnt (stops on halt) and instret_cnt.
module core_mc_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst_b,
    output logic               ifu_req,
    input  logic               ifu_ready,
    input  logic               ifu_rvalid,
    input  logic               ifu_err,
    output logic               ir_load,
    input  logic               dec_mem_read,
    input  logic               dec_mem_write,
    input  logic               dec_jump,
    input  logic               dec_bxx,
    input  logic               bxx_taken,
    input  logic               dec_rd_write,
    input  logic               dec_ebreak,
    output logic               lsu_req,
    input  logic               lsu_ready,
    input  logic               lsu_rvalid,
    input  logic               lsu_err,
    output logic               rf_write,
    output logic               pc_update,
    output logic               pc_sel_target,
    output logic               halt,
    output logic               halt_err,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instret_cnt
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               taken_q, taken_d;
    logic               lsu_acc_q, lsu_acc_d;   // LSU request accepted, awaiting rvalid
    logic               halt_err_q, halt_err_d;
    logic               lsu_go;                 // LSU handshake completes this cycle
    logic               lsu_done;               // LSU response consumed this cycle

    // State and control registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            taken_q    <= 1'b0;
            lsu_acc_q  <= 1'b0;
            halt_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            taken_q    <= taken_d;
            lsu_acc_q  <= lsu_acc_d;
            halt_err_q <= halt_err_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d       = state_q;
        taken_d       = taken_q;
        lsu_acc_d     = lsu_acc_q;
        halt_err_d    = halt_err_q;
        ifu_req       = 1'b0;
        ir_load       = 1'b0;
        lsu_req       = 1'b0;
        rf_write      = 1'b0;
        pc_update     = 1'b0;
        pc_sel_target = 1'b0;
        lsu_go        = 1'b0;
        lsu_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_ready) begin
                    state_d = ST_IWAIT;
                end
            end
            ST_IWAIT: begin
                if (ifu_rvalid) begin
                    if (ifu_err) begin
                        halt_err_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        ir_load = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                state_d = dec_ebreak ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                taken_d   = dec_jump | (dec_bxx & bxx_taken);
                lsu_acc_d = 1'b0;
                state_d   = (dec_mem_read | dec_mem_write) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                lsu_req = ~lsu_acc_q;
                lsu_go  = lsu_req & lsu_ready;
                if (lsu_go) begin
                    lsu_acc_d = 1'b1;
                end
                // The response may arrive in the same cycle as the accept.
                lsu_done = lsu_rvalid & (lsu_acc_q | lsu_go);
                if (lsu_done) begin
                    lsu_acc_d = 1'b0;
                    if (lsu_err) begin
                        halt_err_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_write      = dec_rd_write & ~dec_mem_write;
                pc_update     = 1'b1;
                pc_sel_target = taken_q;
                state_d       = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state    = state_q;
    assign halt     = (state_q == ST_HALT);
    assign halt_err = halt_err_q;

    // Cycle counter freezes once halted.
    perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (~halt),
        .clear (1'b0),
        .count (cycle_cnt)
    );

    // One retirement per WB cycle.
    perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (state_q == ST_WB),
        .clear (1'b0),
        .count (instret_cnt)
    );

endmodule

// File: tb/tb_core_mc_ctrl.sv
// Bench for core_mc_ctrl: acts as IFU/LSU/decoder, pushes expected retire/halt
// events per instruction, and a negedge monitor pops and compares them.
module tb_core_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        ifu_req, ifu_ready, ifu_rvalid, ifu_err, ir_load;
    logic        dec_mem_read, dec_mem_write, dec_jump, dec_bxx, bxx_taken;
    logic        dec_rd_write, dec_ebreak;
    logic        lsu_req, lsu_ready, lsu_rvalid, lsu_err;
    logic        rf_write, pc_update, pc_sel_target, halt, halt_err;
    logic [2:0]  state;
    logic [63:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    core_mc_ctrl #(.CNT_W(64)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .ifu_req       (ifu_req),
        .ifu_ready     (ifu_ready),
        .ifu_rvalid    (ifu_rvalid),
        .ifu_err       (ifu_err),
        .ir_load       (ir_load),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_jump      (dec_jump),
        .dec_bxx       (dec_bxx),
        .bxx_taken     (bxx_taken),
        .dec_rd_write  (dec_rd_write),
        .dec_ebreak    (dec_ebreak),
        .lsu_req       (lsu_req),
        .lsu_ready     (lsu_ready),
        .lsu_rvalid    (lsu_rvalid),
        .lsu_err       (lsu_err),
        .rf_write      (rf_write),
        .pc_update     (pc_update),
        .pc_sel_target (pc_sel_target),
        .halt          (halt),
        .halt_err      (halt_err),
        .state         (state),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    typedef struct {
        bit          is_halt;
        bit          rf;
        bit          tgt;
        bit          herr;
        logic [63:0] instret;
        logic [63:0] cyc;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_cyc;       // cycles consumed since reset, excluding the IDLE cycle
    logic [63:0] m_ret;       // instructions retired since reset
    logic [63:0] m_halt_cyc;  // frozen cycle_cnt expected once halted

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_IWAIT = 3'd2, S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4, S_MEM = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL timeout waiting for %s at %0t", what, $time);
        finish_run();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per retirement (pc_update) or halt entry.
    bit   prev_halt = 1'b0;
    exp_t e;
    always begin
        @(negedge clk);
        #2;
        if (rst_b !== 1'b1) begin
            prev_halt = 1'b0;
        end else begin
            if (pc_update === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("retire_not_halt", 64'(e.is_halt), 64'd0);
                    chk("rf_write", 64'(rf_write), 64'(e.rf));
                    chk("pc_sel_target", 64'(pc_sel_target), 64'(e.tgt));
                    chk("instret_at_wb", instret_cnt, e.instret);
                    chk("cycle_at_wb", cycle_cnt, e.cyc);
                end
            end
            if (halt === 1'b1 && !prev_halt) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_halt", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("halt_expected", 64'(e.is_halt), 64'd1);
                    chk("halt_err", 64'(halt_err), 64'(e.herr));
                    chk("instret_at_halt", instret_cnt, e.instret);
                    chk("cycle_at_halt", cycle_cnt, e.cyc);
                end
            end
            prev_halt = (halt === 1'b1);
        end
    end

    // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 ebreak.
    // a: FETCH cycles before ready; k: IWAIT cycle carrying rvalid (1-based);
    // c: MEM cycles before ready; d: cycles from LSU ready to rvalid.
    task automatic run_instr(input int kind, input int a, input int k, input int c,
                             input int d, input bit ferr, input bit lerr, input bit rdw,
                             input bit tk, output bit halted);
        bit   mr, mw, jmp, bxx, ebk, rd, mem;
        int   fetch_len, mem_len, len, n;
        exp_t x;
        mr  = (kind == 1);
        mw  = (kind == 2);
        bxx = (kind == 3);
        jmp = (kind == 4);
        ebk = (kind == 5);
        rd  = (kind == 1 || kind == 4) ? 1'b1 : ((kind == 0 || kind == 2) ? rdw : 1'b0);
        mem = mr | mw;
        fetch_len = a + 1 + k;
        mem_len   = mem ? (c + 1 + d) : 0;

        // Reference: what the core must report for this instruction.
        x = '{is_halt: 1'b1, rf: 1'b0, tgt: 1'b0, herr: 1'b0, instret: m_ret, cyc: 64'd0};
        if (ferr) begin
            x.herr = 1'b1;
            x.cyc  = 64'd1 + m_cyc + 64'(fetch_len);
        end else if (ebk) begin
            x.cyc  = 64'd1 + m_cyc + 64'(fetch_len + 1);
        end else if (mem && lerr) begin
            x.herr = 1'b1;
            x.cyc  = 64'd1 + m_cyc + 64'(fetch_len + 2 + mem_len);
        end else begin
            len       = fetch_len + 2 + mem_len + 1;
            x.is_halt = 1'b0;
            x.rf      = rd & ~mw;
            x.tgt     = jmp | (bxx & tk);
            x.cyc     = 64'd1 + m_cyc + 64'(len - 1);
            m_ret     = m_ret + 64'd1;
            m_cyc     = m_cyc + 64'(len);
        end
        if (x.is_halt) m_halt_cyc = x.cyc;
        sbq.push_back(x);

        // FETCH handshake.
        n = 0;
        while (ifu_req !== 1'b1) begin
            step();
            n++;
            if (n > 40) timeout("ifu_req");
        end
        chk("state_fetch", 64'(state), 64'(S_FETCH));
        repeat (a) begin
            chk("ifu_req_held", 64'(ifu_req), 64'd1);
            step();
        end
        ifu_ready = 1'b1;
        chk("ifu_req_at_accept", 64'(ifu_req), 64'd1);
        step();
        ifu_ready = 1'b0;
        chk("state_iwait", 64'(state), 64'(S_IWAIT));
        chk("no_dup_ifu_req", 64'(ifu_req), 64'd0);

        // IWAIT: response k cycles in.
        repeat (k - 1) step();
        ifu_rvalid = 1'b1;
        ifu_err    = ferr;
        if (!ferr) begin
            dec_mem_read  = mr;
            dec_mem_write = mw;
            dec_jump      = jmp;
            dec_bxx       = bxx;
            bxx_taken     = tk;
            dec_rd_write  = rd;
            dec_ebreak    = ebk;
        end
        #1;
        chk("ir_load", 64'(ir_load), 64'(!ferr));
        step();
        ifu_rvalid = 1'b0;
        ifu_err    = 1'b0;
        if (ferr) begin
            chk("state_halt_ferr", 64'(state), 64'(S_HALT));
            halted = 1'b1;
            return;
        end
        chk("state_decode", 64'(state), 64'(S_DECODE));
        step();
        if (ebk) begin
            chk("state_halt_ebreak", 64'(state), 64'(S_HALT));
            halted = 1'b1;
            return;
        end
        chk("state_exec", 64'(state), 64'(S_EXEC));
        step();

        if (mem) begin
            chk("state_mem", 64'(state), 64'(S_MEM));
            repeat (c) begin
                chk("lsu_req_held", 64'(lsu_req), 64'd1);
                step();
            end
            lsu_ready = 1'b1;
            chk("lsu_req_at_accept", 64'(lsu_req), 64'd1);
            if (d == 0) begin
                lsu_rvalid = 1'b1;
                lsu_err    = lerr;
            end
            step();
            lsu_ready  = 1'b0;
            lsu_rvalid = 1'b0;
            lsu_err    = 1'b0;
            if (d > 0) begin
                chk("state_mem_wait", 64'(state), 64'(S_MEM));
                chk("lsu_req_dropped", 64'(lsu_req), 64'd0);
                repeat (d - 1) step();
                lsu_rvalid = 1'b1;
                lsu_err    = lerr;
                step();
                lsu_rvalid = 1'b0;
                lsu_err    = 1'b0;
            end
            if (lerr) begin
                chk("state_halt_lerr", 64'(state), 64'(S_HALT));
                halted = 1'b1;
                return;
            end
        end
        chk("state_wb", 64'(state), 64'(S_WB));
        halted = 1'b0;
    endtask

    // Halt is absorbing: stray handshakes ignored, cycle count frozen.
    task automatic check_halt();
        ifu_ready  = 1'b1;
        ifu_rvalid = 1'b1;
        lsu_ready  = 1'b1;
        lsu_rvalid = 1'b1;
        repeat (3) step();
        ifu_ready  = 1'b0;
        ifu_rvalid = 1'b0;
        lsu_ready  = 1'b0;
        lsu_rvalid = 1'b0;
        step();
        chk("halt_stays", 64'(state), 64'(S_HALT));
        chk("halt_flag", 64'(halt), 64'd1);
        chk("halt_no_ifu_req", 64'(ifu_req), 64'd0);
        chk("halt_no_lsu_req", 64'(lsu_req), 64'd0);
        chk("halt_cycle_frozen", cycle_cnt, m_halt_cyc);
        chk("halt_instret", instret_cnt, m_ret);
    endtask

    task automatic chk_reset_vals();
        chk("rst_state", 64'(state), 64'(S_IDLE));
        chk("rst_ifu_req", 64'(ifu_req), 64'd0);
        chk("rst_ir_load", 64'(ir_load), 64'd0);
        chk("rst_lsu_req", 64'(lsu_req), 64'd0);
        chk("rst_rf_write", 64'(rf_write), 64'd0);
        chk("rst_pc_update", 64'(pc_update), 64'd0);
        chk("rst_pc_sel", 64'(pc_sel_target), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_halt_err", 64'(halt_err), 64'd0);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret_cnt", instret_cnt, 64'd0);
    endtask

    task automatic do_reset();
        chk("pending_expectations", 64'(sbq.size()), 64'd0);
        sbq.delete();
        rst_b = 1'b0;
        {ifu_ready, ifu_rvalid, ifu_err, lsu_ready, lsu_rvalid, lsu_err} = '0;
        {dec_mem_read, dec_mem_write, dec_jump, dec_bxx, bxx_taken, dec_rd_write, dec_ebreak} = '0;
        #1;
        chk_reset_vals();
        step();
        rst_b = 1'b1;
        m_cyc = 64'd0;
        m_ret = 64'd0;
    endtask

    initial begin
        #2_000_000;
        timeout("global watchdog");
    end

    initial begin
        bit halted;
        int r, kind, kk;
        rst_b = 1'b0;
        {ifu_ready, ifu_rvalid, ifu_err, lsu_ready, lsu_rvalid, lsu_err} = '0;
        {dec_mem_read, dec_mem_write, dec_jump, dec_bxx, bxx_taken, dec_rd_write, dec_ebreak} = '0;
        m_cyc = 64'd0;
        m_ret = 64'd0;
        m_halt_cyc = 64'd0;
        repeat (3) step();
        chk_reset_vals();
        rst_b = 1'b1;

        // Directed: addi zero-wait, slow IFU, lw, sw, beq taken/not, jal, ebreak.
        run_instr(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, halted);
        run_instr(0, 3, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, halted);
        run_instr(1, 0, 1, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0, halted);
        run_instr(2, 1, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, halted);
        run_instr(3, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, halted);
        run_instr(3, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, halted);
        run_instr(4, 2, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, halted);
        run_instr(5, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, halted);
        chk("ebreak_halted", 64'(halted), 64'd1);
        check_halt();
        do_reset();

        // Reset during an open fetch request; a stale response after release is ignored.
        while (ifu_req !== 1'b1) step();
        rst_b = 1'b0;
        #1;
        chk("async_req_drop", 64'(ifu_req), 64'd0);
        chk("async_state_idle", 64'(state), 64'(S_IDLE));
        step();
        rst_b      = 1'b1;
        ifu_rvalid = 1'b1;
        step();
        ifu_rvalid = 1'b0;
        chk("stale_rvalid_ignored", 64'(state), 64'(S_FETCH));

        // Fetch bus error, then data bus error.
        run_instr(0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, halted);
        run_instr(0, 1, 2, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, halted);
        check_halt();
        do_reset();
        run_instr(1, 0, 1, 1, 2, 1'b0, 1'b1, 1'b1, 1'b0, halted);
        check_halt();
        do_reset();

        // Randomized instruction stream with random handshake latencies.
        for (int i = 0; i < 150; i++) begin
            r    = $urandom_range(0, 39);
            kk   = $urandom_range(0, 6);
            kind = (r == 0) ? 5 : ((kk < 3) ? 0 : kk - 2);
            run_instr(kind, $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), halted);
            if (halted) begin
                check_halt();
                do_reset();
            end
        end
        repeat (3) step();
        chk("final_queue_empty", 64'(sbq.size()), 64'd0);
        finish_run();
    end

endmodule
